// File: rtl/mem_dpi_port_if.sv
// Request/response bus for mem_dpi_port, plus the pmem_read/pmem_write access functions.
// Here the access functions are a byte-masked 64-bit word store with call counters.
interface mem_dpi_port_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_wen;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_mask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_is_write;
  logic                  rsp_err;

  // Physical memory: 64-bit words keyed by 8-byte aligned address; absent words read as 0.
  logic [63:0] mem [logic [63:0]];
  int unsigned dpi_reads  = 0;
  int unsigned dpi_writes = 0;

  function automatic void pmem_write(input logic [63:0] addr, input logic [63:0] data,
                                     input logic [7:0] mask);
    logic [63:0] key;
    logic [63:0] word;
    key  = {addr[63:3], 3'b000};
    word = mem.exists(key) ? mem[key] : '0;
    for (int unsigned i = 0; i < 8; i++)
      if (mask[i]) word[i*8 +: 8] = data[i*8 +: 8];
    mem[key] = word;
    dpi_writes++;
  endfunction

  function automatic void pmem_read(input logic [63:0] addr, output logic [63:0] data);
    logic [63:0] key;
    key  = {addr[63:3], 3'b000};
    data = mem.exists(key) ? mem[key] : '0;
    dpi_reads++;
  endfunction

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_is_write, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_is_write, rsp_err,
    import pmem_read,
    import pmem_write
  );
endinterface

// File: rtl/mem_dpi_port.sv
// Single-outstanding memory port with valid/ready handshake and programmable latency.
// Optional MEM_ALIGN_CHECK_EN: misaligned requests skip memory access and report rsp_err.
module mem_dpi_port #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned LATENCY = 1
) (
  input  logic           clock,
  input  logic           reset,
  mem_dpi_port_if.slave  bus
);
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam logic [3:0]  LAT    = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   mask_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                is_write_q;
  logic [63:0]         rd64;

  logic                accept;
  logic                do_access;
  logic                misaligned;
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_wen;
  logic [DATA_W-1:0]   acc_wdata;
  logic [MASK_W-1:0]   acc_mask;

  assign bus.req_ready    = (state_q == IDLE) && !reset;
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_is_write = is_write_q;

  // Access operands come straight from the request when LATENCY==0, else from the latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    acc_addr  = addr_q;
    acc_wen   = wen_q;
    acc_wdata = wdata_q;
    acc_mask  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          acc_addr  = bus.req_addr;
          acc_wen   = bus.req_wen;
          acc_wdata = bus.req_wdata;
          acc_mask  = bus.req_mask;
          if (LAT == 4'd0) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d   = LAT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  localparam int unsigned OFF_W = $clog2(MASK_W);
  logic err_q;

  assign misaligned  = |acc_addr[OFF_W-1:0];
  assign bus.rsp_err = err_q;

  always_ff @(posedge clock) begin
    if (reset)          err_q <= 1'b0;
    else if (do_access) err_q <= misaligned;
  end
`else
  assign misaligned  = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // Memory calls sit only in the non-reset branch, so reset always suppresses them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= acc_addr;
        wen_q   <= acc_wen;
        wdata_q <= acc_wdata;
        mask_q  <= acc_mask;
      end
      if (do_access) begin
        if (misaligned) begin
          rdata_q    <= '0;
          is_write_q <= acc_wen;
        end else if (acc_wen) begin
          bus.pmem_write(64'(acc_addr), 64'(acc_wdata), 8'(acc_mask));
          rdata_q    <= '0;
          is_write_q <= 1'b1;
        end else begin
          bus.pmem_read(64'(acc_addr), rd64);
          rdata_q    <= rd64[DATA_W-1:0];
          is_write_q <= 1'b0;
        end
      end
    end
  end
endmodule
